// File: rtl/bus_timer_pkg.sv
// Shared definitions for the bus_timer peripheral: FSM encoding, register map,
// CTRL field positions, mode codes and a byte-lane write merge helper.
package bus_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  // Replace each byte lane of old_val whose enable is set with the matching lane of new_val.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_val[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_val[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_timer.sv
// Memory-mapped countdown timer on the processor bridge: CTRL/PRESET/COUNT
// registers, a four-state count FSM and a registered interrupt line.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        irq
);

  state_t      state_r;
  state_t      state_next_s;
  logic [3:0]  ctrl_r;
  logic [31:0] preset_r;
  logic [31:0] count_r;
  logic        flag_r;
  logic        pulse_r;
  logic        irq_r;

  logic        sel_s;
  logic        wr_ctrl_s;
  logic        wr_preset_s;
  logic        en_s;
  logic [1:0]  mode_s;
  logic        load_s;
  logic        dec_s;
  logic        fire_s;
  logic        reload_s;

  logic [3:0]  ctrl_fsm_s;
  logic [31:0] ctrl_merge_s;
  logic [3:0]  ctrl_next_s;
  logic [31:0] preset_next_s;
  logic [31:0] count_next_s;
  logic        flag_next_s;
  logic        unused_s;

  assign sel_s       = (addr[31:4] == BASE_ADDR[31:4]);
  assign wr_ctrl_s   = we & sel_s & (addr[3:2] == REG_CTRL);
  assign wr_preset_s = we & sel_s & (addr[3:2] == REG_PRESET);
  assign en_s        = ctrl_r[CTRL_EN];
  assign mode_s      = ctrl_r[CTRL_MODE_HI:CTRL_MODE_LO];
  assign unused_s    = ^{addr[1:0], ctrl_merge_s[31:4]};

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (en_s) state_next_s = ST_LOAD;
        else      state_next_s = ST_IDLE;
      end
      ST_LOAD: state_next_s = ST_CNT;
      ST_CNT: begin
        if (!en_s)                   state_next_s = ST_IDLE;
        else if (count_r == 32'd0)   state_next_s = ST_INT;
        else                         state_next_s = ST_CNT;
      end
      ST_INT: begin
        if (mode_s == MODE_RELOAD) state_next_s = ST_LOAD;
        else                       state_next_s = ST_IDLE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs: datapath actions for the current state
  always_comb begin
    load_s   = 1'b0;
    dec_s    = 1'b0;
    fire_s   = 1'b0;
    reload_s = 1'b0;
    case (state_r)
      ST_IDLE: load_s = 1'b0;
      ST_LOAD: load_s = 1'b1;
      ST_CNT:  dec_s  = en_s & (count_r != 32'd0);
      ST_INT: begin
        fire_s = 1'b1;
        case (mode_s)
          MODE_RELOAD:  reload_s = 1'b1;
          MODE_ONESHOT: reload_s = 1'b0;
          default:      reload_s = 1'b0;
        endcase
      end
      default: load_s = 1'b0;
    endcase
  end

  // Next register values; a CPU write to a CTRL byte overrides the FSM's EN clear
  always_comb begin
    ctrl_fsm_s = ctrl_r;
    if (fire_s && !reload_s) ctrl_fsm_s[CTRL_EN] = 1'b0;
    else                     ctrl_fsm_s[CTRL_EN] = ctrl_r[CTRL_EN];

    ctrl_merge_s = merge_bytes({28'd0, ctrl_fsm_s}, wdata, be);
    if (wr_ctrl_s) ctrl_next_s = ctrl_merge_s[3:0];
    else           ctrl_next_s = ctrl_fsm_s;

    if (wr_preset_s) preset_next_s = merge_bytes(preset_r, wdata, be);
    else             preset_next_s = preset_r;

    if (load_s)     count_next_s = preset_r;
    else if (dec_s) count_next_s = count_r - 32'd1;
    else            count_next_s = count_r;

    // Firing wins over a clearing write in the same cycle so no event is lost
    if (fire_s)                          flag_next_s = 1'b1;
    else if (wr_ctrl_s || wr_preset_s)   flag_next_s = 1'b0;
    else if (pulse_r)                    flag_next_s = 1'b0;
    else                                 flag_next_s = flag_r;
  end

  // Register file, interrupt flag and irq output
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_r   <= 4'd0;
      preset_r <= 32'd0;
      count_r  <= 32'd0;
      flag_r   <= 1'b0;
      pulse_r  <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      ctrl_r   <= ctrl_next_s;
      preset_r <= preset_next_s;
      count_r  <= count_next_s;
      flag_r   <= flag_next_s;
      pulse_r  <= reload_s;
      irq_r    <= flag_next_s & ctrl_next_s[CTRL_IM];
    end
  end

  // Read mux, decoded from addr alone; the bridge qualifies with its own select
  always_comb begin
    rdata = 32'd0;
    case (addr[3:2])
      REG_CTRL:   rdata = {28'd0, ctrl_r};
      REG_PRESET: rdata = preset_r;
      REG_COUNT:  rdata = count_r;
      default:    rdata = 32'd0;
    endcase
  end

  assign irq = irq_r;

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: directed scenarios with fixed expectations
// plus randomized bus traffic compared against a behavioural timer model.
module tb_bus_timer;

  localparam logic [31:0] BASE = 32'h0000_7F00;
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_RUN = 2, PH_FIRE = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  int          m_phase;
  logic        m_flag;
  logic        m_pulse;
  logic        last_irq;

  always #5 clk = ~clk;

  bus_timer #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .addr(addr), .be(be),
    .wdata(wdata), .we(we), .rdata(rdata), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a[3:2])
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // Advance the timer model by one clock edge given the bus inputs of that cycle.
  task automatic model_step(input logic r, input logic w, input logic [31:0] a,
                            input logic [3:0] b, input logic [31:0] d);
    logic [3:0]  n_ctrl;
    logic [31:0] n_preset, n_count;
    int          n_phase;
    logic        n_flag, n_pulse, hit;
    if (r) begin
      m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0;
      m_phase = PH_IDLE; m_flag = 1'b0; m_pulse = 1'b0;
      return;
    end
    n_ctrl = m_ctrl; n_preset = m_preset; n_count = m_count;
    n_phase = m_phase; n_flag = m_flag; n_pulse = 1'b0;
    hit = w && (a[31:4] == BASE[31:4]);
    if (m_phase == PH_IDLE) begin
      if (m_ctrl[0]) n_phase = PH_LOAD;
    end else if (m_phase == PH_LOAD) begin
      n_count = m_preset;
      n_phase = PH_RUN;
    end else if (m_phase == PH_RUN) begin
      if (!m_ctrl[0])          n_phase = PH_IDLE;
      else if (m_count == 0)   n_phase = PH_FIRE;
      else                     n_count = m_count - 1;
    end else begin
      if (m_ctrl[2:1] == 2'd1) begin
        n_phase = PH_LOAD;
        n_pulse = 1'b1;
      end else begin
        n_ctrl[0] = 1'b0;
        n_phase = PH_IDLE;
      end
    end
    if (m_phase == PH_FIRE)                       n_flag = 1'b1;
    else if (hit && (a[3:2] == 2'd0 || a[3:2] == 2'd1)) n_flag = 1'b0;
    else if (m_pulse)                             n_flag = 1'b0;
    if (hit && a[3:2] == 2'd0 && b[0]) n_ctrl = d[3:0];
    if (hit && a[3:2] == 2'd1) begin
      for (int i = 0; i < 4; i++)
        if (b[i]) n_preset[8*i +: 8] = d[8*i +: 8];
    end
    m_ctrl = n_ctrl; m_preset = n_preset; m_count = n_count;
    m_phase = n_phase; m_flag = n_flag; m_pulse = n_pulse;
  endtask

  // One bus cycle: drive, compare against the model (and optional fixed values), clock.
  task automatic step(input logic r, input logic w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d,
                      input bit do_abs, input string tag,
                      input logic [31:0] e_rd, input logic e_irq);
    reset = r; we = w; addr = a; be = b; wdata = d;
    @(negedge clk);
    last_irq = irq;
    check("rdata_model", rdata, model_read(a));
    check("irq_model", {31'd0, irq}, {31'd0, m_flag & m_ctrl[3]});
    if (do_abs) begin
      check({tag, "_rdata"}, rdata, e_rd);
      check({tag, "_irq"}, {31'd0, irq}, {31'd0, e_irq});
    end
    @(posedge clk);
    model_step(r, w, a, b, d);
    #1;
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d, input logic [3:0] b);
    step(1'b0, 1'b1, BASE + {28'd0, off, 2'b00}, b, d, 1'b0, "", 32'd0, 1'b0);
  endtask

  task automatic rd(input logic [1:0] off);
    step(1'b0, 1'b0, BASE + {28'd0, off, 2'b00}, 4'd0, 32'd0, 1'b0, "", 32'd0, 1'b0);
  endtask

  task automatic expect_rd(input string tag, input logic [1:0] off,
                           input logic [31:0] e_rd, input logic e_irq);
    step(1'b0, 1'b0, BASE + {28'd0, off, 2'b00}, 4'd0, 32'd0, 1'b1, tag, e_rd, e_irq);
  endtask

  logic [31:0] exp_cnt [9] = '{32'd0, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
  int          rises [$];
  logic        rr, rw;
  logic [31:0] ra, rd_data;
  logic [3:0]  rb;

  initial begin
    reset = 1'b1; we = 1'b0; addr = BASE; be = 4'd0; wdata = 32'd0;
    repeat (2) @(posedge clk);
    model_step(1'b1, 1'b0, BASE, 4'd0, 32'd0);
    #1;

    // reset state
    expect_rd("rst_ctrl",   2'd0, 32'd0, 1'b0);
    expect_rd("rst_preset", 2'd1, 32'd0, 1'b0);
    expect_rd("rst_count",  2'd2, 32'd0, 1'b0);
    expect_rd("rst_resv",   2'd3, 32'd0, 1'b0);

    // one-shot, PRESET=3, EN+IM
    wr(2'd1, 32'd3, 4'hF);
    wr(2'd0, 32'h9, 4'hF);
    for (int k = 0; k < 9; k++)
      expect_rd("oneshot_count", 2'd2, exp_cnt[k], (k >= 7));
    expect_rd("oneshot_ctrl", 2'd0, 32'h8, 1'b1);
    wr(2'd0, 32'h0, 4'hF);
    expect_rd("irq_clear", 2'd0, 32'h0, 1'b0);

    // auto-reload, PRESET=2: one-cycle pulses every 5 cycles
    wr(2'd1, 32'd2, 4'hF);
    wr(2'd0, 32'hB, 4'hF);
    rises.delete();
    for (int k = 0; k < 25; k++) begin
      logic prev;
      prev = last_irq;
      rd(2'd2);
      if (k > 0 && last_irq && !prev) rises.push_back(k);
    end
    check("reload_pulses", {31'd0, rises.size() >= 3}, 32'd1);
    if (rises.size() > 0) check("reload_first", rises[0], 32'd6);
    for (int i = 1; i < rises.size(); i++)
      check("reload_period", rises[i] - rises[i-1], 32'd5);
    wr(2'd0, 32'h0, 4'hF);
    repeat (3) rd(2'd2);

    // byte enables and out-of-window write
    wr(2'd1, 32'h0, 4'hF);
    wr(2'd1, 32'hAABBCCDD, 4'b0101);
    expect_rd("be_merge", 2'd1, 32'h00BB00DD, 1'b0);
    step(1'b0, 1'b1, BASE + 32'h10, 4'hF, 32'hFFFF_FFFF, 1'b0, "", 32'd0, 1'b0);
    expect_rd("oow_preset", 2'd1, 32'h00BB00DD, 1'b0);
    expect_rd("oow_ctrl",   2'd0, 32'h0, 1'b0);

    // masked one-shot, then a CTRL write clears the hidden flag
    wr(2'd1, 32'd2, 4'hF);
    wr(2'd0, 32'h1, 4'hF);
    repeat (8) rd(2'd0);
    expect_rd("masked_ctrl", 2'd0, 32'h0, 1'b0);
    wr(2'd0, 32'h8, 4'hF);
    expect_rd("unmask_ctrl", 2'd0, 32'h8, 1'b0);
    expect_rd("unmask_irq",  2'd2, 32'h0, 1'b0);

    // reset while COUNT=5
    wr(2'd1, 32'd10, 4'hF);
    wr(2'd0, 32'h9, 4'hF);
    repeat (7) rd(2'd2);
    step(1'b1, 1'b0, BASE + 32'h8, 4'd0, 32'd0, 1'b1, "pre_reset_count", 32'd5, 1'b0);
    expect_rd("post_reset_count",  2'd2, 32'd0, 1'b0);
    expect_rd("post_reset_ctrl",   2'd0, 32'd0, 1'b0);
    expect_rd("post_reset_preset", 2'd1, 32'd0, 1'b0);
    expect_rd("post_reset_hold",   2'd2, 32'd0, 1'b0);

    // randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      rr = ($urandom_range(0, 99) == 0);
      rw = ($urandom_range(0, 3) == 0);
      ra = BASE | {28'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 9) == 0) ra = ra ^ (32'd1 << $urandom_range(4, 31));
      rb = 4'($urandom);
      rd_data = $urandom;
      if (ra[3:2] == 2'd1) rd_data = 32'($urandom_range(0, 9));
      step(rr, rw, ra, rb, rd_data, 1'b0, "", 32'd0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_timer.md
Name: bus_timer

Overview:
- Memory-mapped countdown timer that acts as the responder on the processor bridge bus (address / byte-enable / write-data / write-enable / read-data).
- Raises one hardware interrupt line into the CPU's HWInt vector (wired to HWInt[2]).
- Sits on the bridge next to other peripherals. It decodes its own 16-byte address window, and software programs it with sw/lw.

Parameters:
- BASE_ADDR, 32'h0000_7F00, byte address of the register window; must be 16-byte aligned.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  bus byte address (PrAddr).
- be  in  4  byte enables for writes (PrBE); be[i] covers wdata[8i+7:8i].
- wdata  in  32  write data (PrWD).
- we  in  1  write strobe (PrWE); only honoured when addr falls inside the window.
- rdata  out  32  read data, combinational from addr (feeds PrRD).
- irq  out  1  interrupt request, registered, to HWInt[2].

Behaviour:
- Window select: sel = (addr[31:4] == BASE_ADDR[31:4]). addr[1:0] is ignored.
- Register map by addr[3:2]:
  - 0 = CTRL, read/write. Bit 0 EN, bits 2:1 MODE, bit 3 IM (interrupt mask). Bits 31:4 read 0 and are not writable.
  - 1 = PRESET, read/write, 32 bits.
  - 2 = COUNT, read-only; writes are ignored.
  - 3 = reserved; reads 0, writes ignored.
- Writes: on a clock edge with we & sel, each byte lane with be[i]=1 is updated. A written value is visible on rdata from the next cycle. rdata is valid whenever addr is applied, regardless of sel; the bridge does the muxing.
- Reset: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, irq=0.
- FSM states, 2-bit: IDLE, LOAD, CNT, INT.
  - IDLE: if EN=1, go to LOAD; else stay. COUNT holds.
  - LOAD: COUNT <= PRESET, go to CNT.
  - CNT: if EN=0, go to IDLE with COUNT frozen. Else if COUNT==0, go to INT. Else COUNT <= COUNT-1. Decrement never wraps.
  - INT, MODE=0 (one-shot): EN <= 0, irq_flag <= 1 (sticky), go to IDLE.
  - INT, MODE=1 (auto-reload): irq_flag <= 1 for exactly one cycle (cleared on the following edge unless set again), go to LOAD.
  - MODE=2 and MODE=3 behave as MODE=0.
- irq = irq_flag & IM, from registered signals with no combinational path from bus inputs.
- The sticky irq_flag (MODE 0) is cleared by any in-window write to CTRL or PRESET.
- Timing, one-shot, PRESET=P, EN written at edge E0:
  - LOAD at E1, COUNT=P at E2, COUNT=0 at E2+P, INT at E3+P.
  - irq high from edge E4+P onward.
- Simultaneous events:
  - A CPU write to CTRL in the same cycle the FSM clears EN (INT, MODE 0): the CPU write wins for all written bytes.
  - A PRESET write while in CNT does not affect COUNT until the next LOAD.
  - Clearing EN while in INT: the INT action still completes; in MODE 1 the next LOAD is entered and then falls to IDLE from CNT.
- Reset mid-count: everything returns to reset values on that edge and irq drops the following cycle.

Decomposition:
- Shared package (bus_timer_pkg): state encoding constants; register offsets CTRL=2'd0, PRESET=2'd1, COUNT=2'd2; CTRL bit positions EN=0, MODE=2:1, IM=3; mode constants.
- No sub-module. Byte-lane write merge is a small function in the package, reusable by other bridge peripherals.

Test Plan:
- Reset, then read all offsets -> rdata=0 for CTRL/PRESET/COUNT/reserved; irq=0.
- Write PRESET=3, then CTRL=32'h9 (EN, IM, mode0) -> COUNT reads 3,2,1,0 on successive cycles from E2; irq rises at E7 and stays high; CTRL reads 32'h8 (EN cleared). Then write CTRL=0 -> irq low next cycle.
- Mode1: PRESET=2, CTRL=32'hB -> irq pulses for 1 cycle; period between pulses = PRESET+3 = 5 cycles; at least 3 pulses checked.
- Byte enables: write PRESET=32'hAABBCCDD with be=4'b0101 over a zero PRESET -> reads 32'h00BB00DD. A write with addr = BASE_ADDR+32'h10 -> no register change.
- Count with IM=0 in mode0 -> irq stays 0 and EN still clears. Then set IM=1 without clearing the flag (write CTRL clears it) -> irq stays 0. This confirms that a CTRL write clears the flag.
- Assert reset while COUNT=5 in CNT -> COUNT=0, CTRL=0, irq=0 after the edge; no further decrement.
